// File: rtl/spi_master_xcvr_pkg.sv
// Shared definitions for the SPI master transceiver: CPU word width,
// FSM state encodings and a sizing helper for the bit counter.
package spi_master_xcvr_pkg;

    localparam int W_CPU = 32;

    typedef enum logic [1:0] {
        SPI_ST_IDLE  = 2'd0,
        SPI_ST_LEAD  = 2'd1,
        SPI_ST_XFER  = 2'd2,
        SPI_ST_TRAIL = 2'd3
    } spi_state_e;

    // Bit counter must be able to hold the value w itself, not only w-1
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/spi_master_xcvr_clkgen.sv
// SCLK generator: counts half-periods of div+1 clk cycles while enabled,
// toggles SCLK at the end of each one and flags whether that toggle is the
// leading (away from CPOL) or trailing (back to CPOL) edge of a bit.
module spi_master_xcvr_clkgen
    import spi_master_xcvr_pkg::*;
#(
    parameter int W_DIV = 8,
    parameter bit CPOL  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [W_DIV-1:0] div_i,
    output logic             lead_stb_o,
    output logic             trail_stb_o,
    output logic             sclk_o
);

    logic [W_DIV-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             hp_end;

    // Next-state: reload while disabled so the first half-period is full length
    always_comb begin
        hp_end = en_i && (cnt_q == '0);
        cnt_d  = div_i;
        sclk_d = en_i ? sclk_q : CPOL;
        if (en_i && !hp_end) begin
            cnt_d = cnt_q - W_DIV'(1);
        end
        if (hp_end) begin
            sclk_d = ~sclk_q;
        end
    end

    // Half-period counter and SCLK level registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // A toggle from the idle level is the leading edge of a bit
    assign lead_stb_o  = hp_end && (sclk_q == CPOL);
    assign trail_stb_o = hp_end && (sclk_q != CPOL);
    assign sclk_o      = sclk_q;

endmodule

// File: rtl/spi_master_xcvr.sv
// Full-duplex SPI master. A valid/ready word interface starts a frame:
// chip select asserts for one half-period, W_DATA bits are exchanged on
// MOSI/MISO, chip select holds for one more half-period, then the received
// word is presented with a one-cycle rx_valid pulse.
module spi_master_xcvr
    import spi_master_xcvr_pkg::*;
#(
    parameter int W_DATA    = W_CPU,
    parameter int W_DIV     = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DIV-1:0]  div,
    input  logic [W_DATA-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int W_CNT = cnt_width(W_DATA);

    spi_state_e        state_q;
    logic [W_DATA-1:0] tx_sh_q;
    logic [W_DATA-1:0] rx_sh_q;
    logic [W_DATA-1:0] rx_data_q;
    logic [W_DIV-1:0]  div_q;
    logic [W_DIV-1:0]  wait_q;
    logic [W_CNT-1:0]  bit_cnt_q;
    logic              cs_n_q, mosi_q, tx_ready_q, busy_q, rx_valid_q;

    logic              clk_en, lead_stb, trail_stb;
    logic              sample_stb, shift_stb, last_bit;

    // Bit that goes on the wire next, given the configured bit order
    function automatic logic head_bit(input logic [W_DATA-1:0] v);
        return LSB_FIRST ? v[0] : v[W_DATA-1];
    endfunction

    // Discard the bit just driven so the next one becomes the head
    function automatic logic [W_DATA-1:0] shift_out(input logic [W_DATA-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    // Insert a received bit so the first one ends at the first-sent position
    function automatic logic [W_DATA-1:0] shift_in(input logic [W_DATA-1:0] v, input logic b);
        return LSB_FIRST ? {b, v[W_DATA-1:1]} : {v[W_DATA-2:0], b};
    endfunction

    assign clk_en     = (state_q == SPI_ST_XFER);
    assign last_bit   = ((bit_cnt_q + W_CNT'(1)) == W_CNT'(W_DATA));
    assign sample_stb = CPHA ? trail_stb : lead_stb;
    // CPHA=0 already drove bit 0 at accept; its trailing edges load bits 1..W-1 only
    assign shift_stb  = CPHA ? lead_stb : (trail_stb && !last_bit);

    spi_master_xcvr_clkgen #(
        .W_DIV (W_DIV),
        .CPOL  (CPOL)
    ) u_clkgen (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (clk_en),
        .div_i       (div_q),
        .lead_stb_o  (lead_stb),
        .trail_stb_o (trail_stb),
        .sclk_o      (sclk)
    );

    // Frame sequencer with registered pin/handshake outputs and shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SPI_ST_IDLE;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            div_q      <= '0;
            wait_q     <= '0;
            bit_cnt_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                SPI_ST_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        div_q      <= div;
                        wait_q     <= div;
                        bit_cnt_q  <= '0;
                        rx_sh_q    <= '0;
                        cs_n_q     <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SPI_ST_LEAD;
                        if (!CPHA) begin
                            mosi_q  <= head_bit(tx_data);
                            tx_sh_q <= shift_out(tx_data);
                        end else begin
                            tx_sh_q <= tx_data;
                        end
                    end
                end
                SPI_ST_LEAD: begin
                    if (wait_q == '0) begin
                        state_q <= SPI_ST_XFER;
                    end else begin
                        wait_q <= wait_q - W_DIV'(1);
                    end
                end
                SPI_ST_XFER: begin
                    if (sample_stb) begin
                        rx_sh_q <= shift_in(rx_sh_q, miso);
                    end
                    if (shift_stb) begin
                        mosi_q  <= head_bit(tx_sh_q);
                        tx_sh_q <= shift_out(tx_sh_q);
                    end
                    if (trail_stb) begin
                        bit_cnt_q <= bit_cnt_q + W_CNT'(1);
                        if (last_bit) begin
                            state_q <= SPI_ST_TRAIL;
                            wait_q  <= div_q;
                        end
                    end
                end
                SPI_ST_TRAIL: begin
                    if (wait_q == '0) begin
                        state_q    <= SPI_ST_IDLE;
                        cs_n_q     <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                    end else begin
                        wait_q <= wait_q - W_DIV'(1);
                    end
                end
                default: begin
                    state_q <= SPI_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_xcvr.sv
// Bench for spi_master_xcvr: five instances cover the four CPOL/CPHA modes
// at 8 bits and a 32-bit LSB-first build. Each instance has an SPI slave
// model that either loops MOSI back or shifts out its own word, and records
// what it received on MOSI and how many SCLK edges it saw under chip select.
`timescale 1ns/1ps
module tb_spi_master_xcvr;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  div;
    logic [31:0] tx_data;
    logic [NI-1:0] txv;
    logic [31:0] slv_word [NI];
    bit          loop_en  [NI];

    wire [NI-1:0] sclk_a, cs_a, mosi_a, rxv_a, busy_a, rdy_a;
    wire [31:0]   rxd_a  [NI];
    wire [31:0]   cap_a  [NI];
    wire [31:0]   edge_a [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GW   = (g == 4) ? 32 : 8;
        localparam bit GPOL = (g == 2 || g == 3);
        localparam bit GPHA = (g == 1 || g == 3);
        localparam bit GLSB = (g == 4);

        logic          sclk, cs_n, mosi, miso, rxv, busy, rdy;
        logic          miso_s = 1'b0;
        logic [GW-1:0] rxd;
        logic [31:0]   cap = '0;
        int            idx = 0;
        int            edges = 0;
        logic          prev_cs, prev_sclk;

        function automatic int pos(input int i);
            return GLSB ? i : (GW - 1 - i);
        endfunction

        spi_master_xcvr #(
            .W_DATA    (GW),
            .W_DIV     (8),
            .CPOL      (GPOL),
            .CPHA      (GPHA),
            .LSB_FIRST (GLSB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .div      (div),
            .tx_data  (tx_data[GW-1:0]),
            .tx_valid (txv[g]),
            .tx_ready (rdy),
            .rx_data  (rxd),
            .rx_valid (rxv),
            .busy     (busy),
            .sclk     (sclk),
            .mosi     (mosi),
            .miso     (miso),
            .cs_n     (cs_n)
        );

        assign miso = loop_en[g] ? mosi : miso_s;

        // Behavioural SPI slave: drives on the shift edge, captures on the sample edge
        always @(cs_n or sclk) begin
            if (cs_n === 1'b0 && prev_cs !== 1'b0) begin
                idx   = 0;
                edges = 0;
                cap   = '0;
                if (!GPHA) miso_s = slv_word[g][pos(0)];
            end else if (cs_n === 1'b0 && sclk !== prev_sclk) begin
                edges++;
                if (sclk !== GPOL) begin
                    if (idx < GW) begin
                        if (GPHA) miso_s = slv_word[g][pos(idx)];
                        else      cap[pos(idx)] = mosi;
                    end
                end else begin
                    if (GPHA) begin
                        if (idx < GW) cap[pos(idx)] = mosi;
                        idx++;
                    end else begin
                        idx++;
                        if (idx < GW) miso_s = slv_word[g][pos(idx)];
                    end
                end
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end

        assign sclk_a[g] = sclk;
        assign cs_a[g]   = cs_n;
        assign mosi_a[g] = mosi;
        assign rxv_a[g]  = rxv;
        assign busy_a[g] = busy;
        assign rdy_a[g]  = rdy;
        assign rxd_a[g]  = 32'(rxd);
        assign cap_a[g]  = cap;
        assign edge_a[g] = 32'(edges);
    end

    // One complete frame on instance i, checked against the expected SPI exchange
    task automatic run_frame(input int i, input logic [31:0] data, input logic [7:0] d,
                             input logic [31:0] sw, input bit lb);
        int w, lat, cyc;
        bit cpol, seen, in_ok;
        logic [31:0] mask, exp_rx;
        logic lastb;
        w      = (i == 4) ? 32 : 8;
        cpol   = (i == 2 || i == 3);
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        exp_rx = (lb ? data : sw) & mask;
        lat    = (2 * w + 2) * (int'(d) + 1);
        lastb  = (i == 4) ? data[31] : data[0];
        slv_word[i] = sw;
        loop_en[i]  = lb;
        @(negedge clk);
        total++;
        if (rdy_a[i] !== 1'b1) begin
            bad++; $display("FAIL ready_before_accept inst=%0d got=%b want=1", i, rdy_a[i]);
        end
        tx_data = data; div = d; txv[i] = 1'b1;
        @(posedge clk); #1;
        txv[i] = 1'b0;
        in_ok = (rdy_a[i] === 1'b0) && (busy_a[i] === 1'b1) && (cs_a[i] === 1'b0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (rxv_a[i] === 1'b1) seen = 1;
            else if (!(rdy_a[i] === 1'b0 && busy_a[i] === 1'b1 && cs_a[i] === 1'b0)) in_ok = 0;
        end
        total++;
        if (!seen || cyc != lat) begin
            bad++; $display("FAIL latency inst=%0d got=%0d want=%0d", i, cyc, lat);
        end
        total++;
        if (!in_ok) begin
            bad++; $display("FAIL in_frame_flags inst=%0d got=bad want=ready0_busy1_cs0", i);
        end
        total++;
        if (rxd_a[i] !== exp_rx) begin
            bad++; $display("FAIL rx_data inst=%0d got=%h want=%h", i, rxd_a[i], exp_rx);
        end
        total++;
        if (cap_a[i] !== (data & mask)) begin
            bad++; $display("FAIL mosi_word inst=%0d got=%h want=%h", i, cap_a[i], data & mask);
        end
        total++;
        if (edge_a[i] !== 32'(2 * w)) begin
            bad++; $display("FAIL sclk_edges inst=%0d got=%0d want=%0d", i, edge_a[i], 2 * w);
        end
        total++;
        if (sclk_a[i] !== cpol || cs_a[i] !== 1'b1 || rdy_a[i] !== 1'b1 || busy_a[i] !== 1'b0) begin
            bad++; $display("FAIL idle_pins inst=%0d got=sclk%b cs%b rdy%b busy%b want=sclk%b cs1 rdy1 busy0",
                            i, sclk_a[i], cs_a[i], rdy_a[i], busy_a[i], cpol);
        end
        @(posedge clk); #1;
        total++;
        if (rxv_a[i] !== 1'b0) begin
            bad++; $display("FAIL rx_valid_pulse inst=%0d got=%b want=0", i, rxv_a[i]);
        end
        total++;
        if (mosi_a[i] !== lastb) begin
            bad++; $display("FAIL mosi_hold inst=%0d got=%b want=%b", i, mosi_a[i], lastb);
        end
    endtask

    task automatic test_reset;
        bit cpol;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            cpol = (i == 2 || i == 3);
            total++;
            if (sclk_a[i] !== cpol) begin bad++; $display("FAIL rst_sclk inst=%0d got=%b want=%b", i, sclk_a[i], cpol); end
            total++;
            if (cs_a[i] !== 1'b1) begin bad++; $display("FAIL rst_cs_n inst=%0d got=%b want=1", i, cs_a[i]); end
            total++;
            if (mosi_a[i] !== 1'b0) begin bad++; $display("FAIL rst_mosi inst=%0d got=%b want=0", i, mosi_a[i]); end
            total++;
            if (rdy_a[i] !== 1'b1) begin bad++; $display("FAIL rst_ready inst=%0d got=%b want=1", i, rdy_a[i]); end
            total++;
            if (busy_a[i] !== 1'b0) begin bad++; $display("FAIL rst_busy inst=%0d got=%b want=0", i, busy_a[i]); end
            total++;
            if (rxv_a[i] !== 1'b0) begin bad++; $display("FAIL rst_rx_valid inst=%0d got=%b want=0", i, rxv_a[i]); end
            total++;
            if (rxd_a[i] !== 32'h0) begin bad++; $display("FAIL rst_rx_data inst=%0d got=%h want=0", i, rxd_a[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loopback;
        run_frame(0, 32'h0000_00A5, 8'd1, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++)
            run_frame(0, $urandom, 8'($urandom_range(0, 3)), 32'h0, 1'b1);
    endtask

    task automatic test_modes;
        for (int i = 0; i < 4; i++) begin
            run_frame(i, $urandom, 8'd2, 32'h0000_003C, 1'b0);
            run_frame(i, $urandom, 8'($urandom_range(0, 3)), $urandom, 1'b0);
        end
    endtask

    task automatic test_div0;
        run_frame(2, $urandom, 8'd0, $urandom, 1'b0);
        run_frame(1, $urandom, 8'd0, $urandom, 1'b0);
    endtask

    task automatic test_lsb32;
        run_frame(4, 32'h0000_0001, 8'd1, 32'h8000_0000, 1'b0);
        run_frame(4, $urandom, 8'($urandom_range(0, 2)), $urandom, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc, pulses, first_at, second_at, cs_hi;
        logic [31:0] rx1, rx2;
        loop_en[0] = 1'b1;
        rx1 = '0; rx2 = '0;
        @(negedge clk);
        tx_data = 32'h11; div = 8'd1; txv[0] = 1'b1;
        @(posedge clk); #1;
        tx_data = 32'h22;
        cyc = 0; pulses = 0; cs_hi = 0; first_at = 0; second_at = 0;
        while (pulses < 2 && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            if (rxv_a[0] === 1'b1) begin
                pulses++;
                if (pulses == 1) begin rx1 = rxd_a[0]; first_at = cyc; end
                else begin rx2 = rxd_a[0]; second_at = cyc; end
            end else if (pulses == 1 && txv[0] && rdy_a[0] === 1'b0) begin
                txv[0] = 1'b0;
            end
            if (pulses == 1 && cs_a[0] === 1'b1) cs_hi++;
        end
        txv[0] = 1'b0;
        total++;
        if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
        total++;
        if (rx1 !== 32'h11) begin bad++; $display("FAIL b2b_rx1 got=%h want=11", rx1); end
        total++;
        if (rx2 !== 32'h22) begin bad++; $display("FAIL b2b_rx2 got=%h want=22", rx2); end
        total++;
        if (first_at != 36) begin bad++; $display("FAIL b2b_first_latency got=%0d want=36", first_at); end
        total++;
        if (second_at - first_at != 37) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=37", second_at - first_at);
        end
        total++;
        if (cs_hi != 1) begin bad++; $display("FAIL b2b_cs_gap got=%0d want=1", cs_hi); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ignore_busy;
        int cyc;
        bit seen, rdy_low, idle_ok;
        loop_en[0] = 1'b1;
        @(negedge clk);
        tx_data = 32'h5A; div = 8'd1; txv[0] = 1'b1;
        @(posedge clk); #1;
        txv[0] = 1'b0;
        cyc = 0; seen = 0; rdy_low = 1;
        while (!seen && cyc < 5000) begin
            if (cyc == 12) begin tx_data = 32'hFF; div = 8'd5; txv[0] = 1'b1; end
            else txv[0] = 1'b0;
            @(posedge clk); #1; cyc++;
            if (rxv_a[0] === 1'b1) seen = 1;
            else if (rdy_a[0] !== 1'b0) rdy_low = 0;
        end
        txv[0] = 1'b0;
        div = 8'd1;
        total++;
        if (!seen || cyc != 36) begin bad++; $display("FAIL ign_latency got=%0d want=36", cyc); end
        total++;
        if (rxd_a[0] !== 32'h5A) begin bad++; $display("FAIL ign_rx_data got=%h want=5a", rxd_a[0]); end
        total++;
        if (cap_a[0] !== 32'h5A) begin bad++; $display("FAIL ign_mosi_word got=%h want=5a", cap_a[0]); end
        total++;
        if (!rdy_low) begin bad++; $display("FAIL ign_ready got=high_in_frame want=low"); end
        idle_ok = 1;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy_a[0] !== 1'b0 || cs_a[0] !== 1'b1) idle_ok = 0;
        end
        total++;
        if (!idle_ok) begin bad++; $display("FAIL ign_no_requeue got=busy want=idle"); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit found, quiet;
        loop_en[3] = 1'b1;
        @(negedge clk);
        tx_data = 32'h96; div = 8'd2; txv[3] = 1'b1;
        @(posedge clk); #1;
        txv[3] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        cyc = 0; found = 0;
        while (!found && cyc < 200) begin
            if (sclk_a[3] !== 1'b1) found = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL rmid_sclk_active got=idle want=toggling"); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (cs_a[3] !== 1'b1) begin bad++; $display("FAIL rmid_cs_n got=%b want=1", cs_a[3]); end
        total++;
        if (sclk_a[3] !== 1'b1) begin bad++; $display("FAIL rmid_sclk got=%b want=1", sclk_a[3]); end
        total++;
        if (busy_a[3] !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy_a[3]); end
        total++;
        if (rxv_a[3] !== 1'b0 || rdy_a[3] !== 1'b1 || mosi_a[3] !== 1'b0) begin
            bad++; $display("FAIL rmid_outputs got=rxv%b rdy%b mosi%b want=rxv0 rdy1 mosi0",
                            rxv_a[3], rdy_a[3], mosi_a[3]);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        repeat (60) begin
            @(posedge clk); #1;
            if (rxv_a[3] !== 1'b0 || busy_a[3] !== 1'b0) quiet = 0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL rmid_aborted got=activity want=none"); end
        run_frame(3, $urandom, 8'd1, $urandom, 1'b0);
    endtask

    initial begin
        rst = 1'b1; div = '0; tx_data = '0; txv = '0;
        for (int k = 0; k < NI; k++) begin
            slv_word[k] = '0;
            loop_en[k]  = 1'b0;
        end
        test_reset;
        test_loopback;
        test_modes;
        test_div0;
        test_lsb32;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
